// File: rtl/mem_stage_split.sv
`timescale 1ns/1ps
// MEM pipeline stage that waits on a split-transaction data SRAM (data_ok), buffers load data under
// WB back-pressure and discards responses of flushed requests. Optional feature macro: MEM_FWD_DATA_EN.
//
// Handshake: EX->MEM transfers on ex_to_mem_valid & mem_allowin; MEM->WB transfers on
// mem_to_wb_valid & wb_allowin; neither valid depends on the receiver's ready in the same cycle
// except through mem_allowin = ~valid | (ready_go & wb_allowin).

module mem_stage_split #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int RF_AW  = 5,
    parameter int DISC_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              ex_to_mem_valid,
    output logic              mem_allowin,
    input  logic [PC_W-1:0]   ex_pc,
    input  logic              ex_rf_we,
    input  logic [RF_AW-1:0]  ex_rf_waddr,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic              ex_mem_req,
    input  logic              ex_is_load,
    input  logic [1:0]        ex_ld_size,
    input  logic              ex_ld_unsigned,
    input  logic              data_sram_data_ok,
    input  logic [DATA_W-1:0] data_sram_rdata,
    input  logic              wb_allowin,
    output logic              mem_to_wb_valid,
    output logic [PC_W-1:0]   mem_wb_pc,
    output logic              mem_wb_rf_we,
    output logic [RF_AW-1:0]  mem_wb_rf_waddr,
    output logic [DATA_W-1:0] mem_wb_rf_wdata,
    output logic              mem_fwd_we,
    output logic [RF_AW-1:0]  mem_fwd_waddr,
    output logic [DATA_W-1:0] mem_fwd_wdata,
    output logic              mem_fwd_stall
);

    localparam int LB = $clog2(DATA_W / 8);
    localparam int CW = DISC_W + 2;
    localparam logic [CW-1:0] DISC_MAX = CW'((1 << DISC_W) - 1);

    // Stage state
    logic              valid_q, valid_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              rf_we_q, rf_we_d;
    logic [RF_AW-1:0]  rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] alu_result_q, alu_result_d;
    logic              mem_req_q, mem_req_d;
    logic              is_load_q, is_load_d;
    logic [1:0]        ld_size_q, ld_size_d;
    logic              ld_unsigned_q, ld_unsigned_d;
    logic              buf_valid_q, buf_valid_d;
    logic [DATA_W-1:0] buf_data_q, buf_data_d;
    logic [DISC_W-1:0] disc_cnt_q, disc_cnt_d;

    // Handshake and datapath intermediates
    logic              wait_resp;
    logic              resp_mine;
    logic              resp_take;
    logic              ready_go;
    logic              leave;
    logic [DATA_W-1:0] raw_data;
    logic [7:0]        byte_val;
    logic [15:0]       half_val;
    logic [DATA_W-1:0] word_ext;
    logic [DATA_W-1:0] dword_ext;
    logic [DATA_W-1:0] load_ext;
    logic [DATA_W-1:0] rf_wdata;
    logic [CW-1:0]     disc_inc;
    logic [CW-1:0]     disc_dec;
    logic [CW-1:0]     disc_sum;

    always_comb begin
        wait_resp   = valid_q & mem_req_q & ~buf_valid_q;
        resp_mine   = data_sram_data_ok & (disc_cnt_q == '0);
        // A response with nobody waiting for it is dropped rather than overwriting the buffer.
        resp_take   = resp_mine & wait_resp;
        ready_go    = ~wait_resp | resp_mine;
        leave       = valid_q & ready_go & wb_allowin;
        mem_allowin = ~valid_q | (ready_go & wb_allowin);
    end

    // Load lane extraction from either the live response or the held buffer
    always_comb begin
        raw_data = resp_take ? data_sram_rdata : buf_data_q;
        byte_val = raw_data[{alu_result_q[LB-1:0], 3'b000} +: 8];
        half_val = raw_data[{alu_result_q[LB-1:1], 4'b0000} +: 16];
    end

    generate
        if (DATA_W == 64) begin : g_w64
            logic [31:0] word_val;
            assign word_val  = raw_data[{alu_result_q[2], 5'b00000} +: 32];
            assign word_ext  = {{32{~ld_unsigned_q & word_val[31]}}, word_val};
            assign dword_ext = raw_data;
        end else begin : g_w32
            assign word_ext  = raw_data;
            assign dword_ext = raw_data;
        end
    endgenerate

    always_comb begin
        case (ld_size_q)
            2'd0:    load_ext = {{(DATA_W-8){~ld_unsigned_q & byte_val[7]}}, byte_val};
            2'd1:    load_ext = {{(DATA_W-16){~ld_unsigned_q & half_val[15]}}, half_val};
            2'd2:    load_ext = word_ext;
            default: load_ext = dword_ext;
        endcase
        rf_wdata = is_load_q ? load_ext : alu_result_q;
    end

    // Outstanding responses of killed requests; sum of flush increments and data_ok decrement.
    always_comb begin
        disc_inc = '0;
        if (flush) begin
            disc_inc = {{(CW-1){1'b0}}, valid_q & wait_resp & ~resp_mine}
                     + {{(CW-1){1'b0}}, ex_to_mem_valid & ex_mem_req};
        end
        disc_dec = {{(CW-1){1'b0}}, data_sram_data_ok & (disc_cnt_q != '0)};
        disc_sum = {{(CW-DISC_W){1'b0}}, disc_cnt_q} + disc_inc - disc_dec;
        if (disc_sum > DISC_MAX) begin
            disc_cnt_d = DISC_MAX[DISC_W-1:0];
        end else begin
            disc_cnt_d = disc_sum[DISC_W-1:0];
        end
    end

    always_comb begin
        valid_d       = valid_q;
        pc_d          = pc_q;
        rf_we_d       = rf_we_q;
        rf_waddr_d    = rf_waddr_q;
        alu_result_d  = alu_result_q;
        mem_req_d     = mem_req_q;
        is_load_d     = is_load_q;
        ld_size_d     = ld_size_q;
        ld_unsigned_d = ld_unsigned_q;
        buf_valid_d   = buf_valid_q;
        buf_data_d    = buf_data_q;
        if (flush) begin
            valid_d     = 1'b0;
            buf_valid_d = 1'b0;
        end else begin
            if (mem_allowin) begin
                valid_d = ex_to_mem_valid;
                if (ex_to_mem_valid) begin
                    pc_d          = ex_pc;
                    rf_we_d       = ex_rf_we;
                    rf_waddr_d    = ex_rf_waddr;
                    alu_result_d  = ex_alu_result;
                    mem_req_d     = ex_mem_req;
                    is_load_d     = ex_is_load;
                    ld_size_d     = ex_ld_size;
                    ld_unsigned_d = ex_ld_unsigned;
                end
            end
            if (leave) begin
                buf_valid_d = 1'b0;
            end else if (resp_take & ~wb_allowin) begin
                buf_valid_d = 1'b1;
                buf_data_d  = data_sram_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q       <= 1'b0;
            pc_q          <= '0;
            rf_we_q       <= 1'b0;
            rf_waddr_q    <= '0;
            alu_result_q  <= '0;
            mem_req_q     <= 1'b0;
            is_load_q     <= 1'b0;
            ld_size_q     <= 2'd0;
            ld_unsigned_q <= 1'b0;
            buf_valid_q   <= 1'b0;
            buf_data_q    <= '0;
            disc_cnt_q    <= '0;
        end else begin
            valid_q       <= valid_d;
            pc_q          <= pc_d;
            rf_we_q       <= rf_we_d;
            rf_waddr_q    <= rf_waddr_d;
            alu_result_q  <= alu_result_d;
            mem_req_q     <= mem_req_d;
            is_load_q     <= is_load_d;
            ld_size_q     <= ld_size_d;
            ld_unsigned_q <= ld_unsigned_d;
            buf_valid_q   <= buf_valid_d;
            buf_data_q    <= buf_data_d;
            disc_cnt_q    <= disc_cnt_d;
        end
    end

    always_comb begin
        mem_to_wb_valid = valid_q & ready_go & ~flush;
        mem_wb_pc       = pc_q;
        mem_wb_rf_we    = rf_we_q;
        mem_wb_rf_waddr = rf_waddr_q;
        mem_wb_rf_wdata = rf_wdata;
        mem_fwd_we      = valid_q & rf_we_q;
        mem_fwd_waddr   = rf_waddr_q;
`ifdef MEM_FWD_DATA_EN
        mem_fwd_wdata   = rf_wdata;
        mem_fwd_stall   = valid_q & is_load_q & wait_resp & ~resp_mine;
`else
        // No data forwarding: ID holds off on any load still in MEM.
        mem_fwd_wdata   = '0;
        mem_fwd_stall   = valid_q & is_load_q;
`endif
    end

endmodule

// File: tb/tb_mem_stage_split.sv
`timescale 1ns/1ps
// Bench for mem_stage_split: a 32-bit and a 64-bit instance share the control stimulus; directed
// sequences, a load-extraction vector table and randomized loads checked against a reference model.

module tb_mem_stage_split;

`ifdef MEM_FWD_DATA_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        flush;
    logic        ex_to_mem_valid;
    logic [31:0] ex_pc;
    logic        ex_rf_we;
    logic [4:0]  ex_rf_waddr;
    logic [31:0] ex_alu_result;
    logic [63:0] ex_alu_result64;
    logic        ex_mem_req;
    logic        ex_is_load;
    logic [1:0]  ex_ld_size;
    logic        ex_ld_unsigned;
    logic        data_ok;
    logic [31:0] rdata;
    logic [63:0] rdata64;
    logic        wb_allowin;

    logic        mem_allowin, mem_to_wb_valid, mem_wb_rf_we, mem_fwd_we, mem_fwd_stall;
    logic [31:0] mem_wb_pc, mem_wb_rf_wdata, mem_fwd_wdata;
    logic [4:0]  mem_wb_rf_waddr, mem_fwd_waddr;

    logic        allowin_64, to_wb_64, wb_we_64, fwd_we_64, fwd_stall_64;
    logic [31:0] wb_pc_64;
    logic [63:0] wb_wdata_64, fwd_wdata_64;
    logic [4:0]  wb_waddr_64, fwd_waddr_64;

    mem_stage_split u_dut (
        .clk(clk), .reset(reset), .flush(flush),
        .ex_to_mem_valid(ex_to_mem_valid), .mem_allowin(mem_allowin),
        .ex_pc(ex_pc), .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
        .ex_alu_result(ex_alu_result), .ex_mem_req(ex_mem_req), .ex_is_load(ex_is_load),
        .ex_ld_size(ex_ld_size), .ex_ld_unsigned(ex_ld_unsigned),
        .data_sram_data_ok(data_ok), .data_sram_rdata(rdata), .wb_allowin(wb_allowin),
        .mem_to_wb_valid(mem_to_wb_valid), .mem_wb_pc(mem_wb_pc), .mem_wb_rf_we(mem_wb_rf_we),
        .mem_wb_rf_waddr(mem_wb_rf_waddr), .mem_wb_rf_wdata(mem_wb_rf_wdata),
        .mem_fwd_we(mem_fwd_we), .mem_fwd_waddr(mem_fwd_waddr), .mem_fwd_wdata(mem_fwd_wdata),
        .mem_fwd_stall(mem_fwd_stall)
    );

    mem_stage_split #(.DATA_W(64)) u_dut64 (
        .clk(clk), .reset(reset), .flush(flush),
        .ex_to_mem_valid(ex_to_mem_valid), .mem_allowin(allowin_64),
        .ex_pc(ex_pc), .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
        .ex_alu_result(ex_alu_result64), .ex_mem_req(ex_mem_req), .ex_is_load(ex_is_load),
        .ex_ld_size(ex_ld_size), .ex_ld_unsigned(ex_ld_unsigned),
        .data_sram_data_ok(data_ok), .data_sram_rdata(rdata64), .wb_allowin(wb_allowin),
        .mem_to_wb_valid(to_wb_64), .mem_wb_pc(wb_pc_64), .mem_wb_rf_we(wb_we_64),
        .mem_wb_rf_waddr(wb_waddr_64), .mem_wb_rf_wdata(wb_wdata_64),
        .mem_fwd_we(fwd_we_64), .mem_fwd_waddr(fwd_waddr_64), .mem_fwd_wdata(fwd_wdata_64),
        .mem_fwd_stall(fwd_stall_64)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] pc_ctr = 32'h1000_0000;
    logic [31:0] exp_pc;

    typedef struct {
        bit          is64;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [63:0] rd;
        logic [63:0] exp;
    } vec_t;
    vec_t tbl [0:14];

    // scoreboard
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Load result from the byte-addressed view of the response word.
    function automatic logic [63:0] ref_load(input int dw, input logic [63:0] rd,
                                             input logic [31:0] addr, input logic [1:0] size,
                                             input logic uns);
        int nbytes, off, len;
        logic [63:0] v, mask;
        nbytes = dw / 8;
        off    = int'(addr % nbytes);
        case (size)
            2'd0: len = 1;
            2'd1: begin len = 2; off = off - off % 2; end
            2'd2: begin len = 4; off = (dw == 64) ? off - off % 4 : 0; end
            default: begin len = nbytes; off = 0; end
        endcase
        v    = rd >> (off * 8);
        mask = (len == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (len * 8)) - 64'd1);
        v    = v & mask;
        if (!uns && v[len*8-1]) v = v | ~mask;
        if (dw == 32) v = v & 64'h0000_0000_FFFF_FFFF;
        return v;
    endfunction

    // driver tasks
    task automatic idle_inputs();
        flush = 0; ex_to_mem_valid = 0; ex_mem_req = 0; ex_is_load = 0; ex_rf_we = 0;
        ex_rf_waddr = 0; ex_alu_result = 0; ex_alu_result64 = 0; ex_ld_size = 0;
        ex_ld_unsigned = 0; ex_pc = 0; data_ok = 0; rdata = 0; rdata64 = 0; wb_allowin = 1;
    endtask

    task automatic issue(input logic mreq, input logic ld, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [4:0] wa);
        ex_to_mem_valid = 1; ex_mem_req = mreq; ex_is_load = ld; ex_rf_we = ~(mreq & ~ld);
        ex_ld_size = sz; ex_ld_unsigned = uns; ex_alu_result = a; ex_alu_result64 = {32'h0, a};
        ex_rf_waddr = wa; ex_pc = pc_ctr; exp_pc = pc_ctr; pc_ctr = pc_ctr + 4;
        data_ok = 0;
        settle();
        chk("issue_allowin", {63'd0, mem_allowin}, 64'd1);
        step();
        ex_to_mem_valid = 0; ex_mem_req = 0; ex_is_load = 0; ex_rf_we = 0;
    endtask

    task automatic run_load(input logic [1:0] sz, input logic uns, input logic [31:0] a,
                            input logic [4:0] wa, input logic [31:0] rd32,
                            input logic [63:0] rd64, input int stall, input int hold);
        logic [63:0] e32, e64;
        e32 = ref_load(32, {32'h0, rd32}, a, sz, uns);
        e64 = ref_load(64, rd64, a, sz, uns);
        issue(1, 1, sz, uns, a, wa);
        for (int s = 0; s < stall; s++) begin
            data_ok = 0; wb_allowin = 1;
            settle();
            chk("rnd_stall_to_wb", {63'd0, mem_to_wb_valid}, 64'd0);
            chk("rnd_stall_allowin", {63'd0, mem_allowin}, 64'd0);
            chk("rnd_stall_fwd", {63'd0, mem_fwd_stall}, 64'd1);
            step();
        end
        data_ok = 1; rdata = rd32; rdata64 = rd64; wb_allowin = (hold == 0);
        settle();
        chk("rnd_resp_to_wb", {63'd0, mem_to_wb_valid}, 64'd1);
        chk("rnd_resp_wdata32", {32'h0, mem_wb_rf_wdata}, e32);
        chk("rnd_resp_wdata64", wb_wdata_64, e64);
        chk("rnd_resp_waddr", {59'd0, mem_wb_rf_waddr}, {59'd0, wa});
        chk("rnd_resp_allowin", {63'd0, mem_allowin}, {63'd0, hold == 0});
        step();
        data_ok = 0; rdata = ~rd32; rdata64 = ~rd64;
        for (int h = 1; h <= hold; h++) begin
            wb_allowin = (h == hold);
            settle();
            chk("rnd_buf_to_wb", {63'd0, mem_to_wb_valid}, 64'd1);
            chk("rnd_buf_wdata32", {32'h0, mem_wb_rf_wdata}, e32);
            chk("rnd_buf_wdata64", wb_wdata_64, e64);
            chk("rnd_buf_allowin", {63'd0, mem_allowin}, {63'd0, h == hold});
            step();
        end
        wb_allowin = 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, r32;
        logic [63:0] r64;
        logic [1:0]  sz;
        logic        uns;
        logic [4:0]  wa;
        int          kind, stall, hold;

        tbl[0]  = '{0, 2'd0, 1'b0, 32'h100, 64'h0000_00FF, 64'hFFFF_FFFF};
        tbl[1]  = '{0, 2'd0, 1'b1, 32'h101, 64'h0000_AB00, 64'h0000_00AB};
        tbl[2]  = '{0, 2'd0, 1'b0, 32'h102, 64'h007F_0000, 64'h0000_007F};
        tbl[3]  = '{0, 2'd1, 1'b0, 32'h200, 64'h0000_8001, 64'hFFFF_8001};
        tbl[4]  = '{0, 2'd1, 1'b1, 32'h202, 64'hBEEF_0000, 64'h0000_BEEF};
        tbl[5]  = '{0, 2'd1, 1'b0, 32'h202, 64'h7FFF_1234, 64'h0000_7FFF};
        tbl[6]  = '{0, 2'd2, 1'b0, 32'h300, 64'hCAFE_BABE, 64'hCAFE_BABE};
        tbl[7]  = '{0, 2'd3, 1'b0, 32'h300, 64'h8765_4321, 64'h8765_4321};
        tbl[8]  = '{1, 2'd2, 1'b1, 32'h404, 64'hF000_0001_0000_0002, 64'h0000_0000_F000_0001};
        tbl[9]  = '{1, 2'd2, 1'b0, 32'h404, 64'hF000_0001_0000_0002, 64'hFFFF_FFFF_F000_0001};
        tbl[10] = '{1, 2'd2, 1'b0, 32'h400, 64'hF000_0001_0000_0002, 64'h0000_0000_0000_0002};
        tbl[11] = '{1, 2'd3, 1'b0, 32'h400, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001};
        tbl[12] = '{1, 2'd0, 1'b0, 32'h407, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FF80};
        tbl[13] = '{1, 2'd1, 1'b1, 32'h406, 64'h1234_0000_0000_0000, 64'h0000_0000_0000_1234};
        tbl[14] = '{1, 2'd1, 1'b0, 32'h402, 64'h0000_0000_ABCD_0000, 64'hFFFF_FFFF_FFFF_ABCD};

        // reset state
        idle_inputs();
        reset = 1;
        repeat (3) step();
        reset = 0;
        settle();
        chk("rst_allowin", {63'd0, mem_allowin}, 64'd1);
        chk("rst_to_wb", {63'd0, mem_to_wb_valid}, 64'd0);
        chk("rst_wdata", {32'h0, mem_wb_rf_wdata}, 64'd0);
        chk("rst_pc", {32'h0, mem_wb_pc}, 64'd0);
        chk("rst_fwd_we", {63'd0, mem_fwd_we}, 64'd0);
        chk("rst_fwd_stall", {63'd0, mem_fwd_stall}, 64'd0);
        chk("rst_wb_we", {63'd0, mem_wb_rf_we}, 64'd0);

        // ALU op: one-cycle latency
        issue(0, 0, 2'd0, 0, 32'h1234, 5'd5);
        settle();
        chk("alu_to_wb", {63'd0, mem_to_wb_valid}, 64'd1);
        chk("alu_wdata", {32'h0, mem_wb_rf_wdata}, 64'h1234);
        chk("alu_waddr", {59'd0, mem_wb_rf_waddr}, 64'd5);
        chk("alu_we", {63'd0, mem_wb_rf_we}, 64'd1);
        chk("alu_pc", {32'h0, mem_wb_pc}, {32'h0, exp_pc});
        chk("alu_allowin", {63'd0, mem_allowin}, 64'd1);
        chk("alu_fwd_we", {63'd0, mem_fwd_we}, 64'd1);
        chk("alu_fwd_wdata", {32'h0, mem_fwd_wdata}, FWD_EN ? 64'h1234 : 64'h0);
        step();
        settle();
        chk("alu_gone", {63'd0, mem_to_wb_valid}, 64'd0);

        // back-to-back ALU ops
        ex_to_mem_valid = 1; ex_rf_we = 1; ex_alu_result = 32'h11; ex_rf_waddr = 5'd1;
        step();
        ex_alu_result = 32'h22; ex_rf_waddr = 5'd2;
        settle();
        chk("b2b_first_wdata", {32'h0, mem_wb_rf_wdata}, 64'h11);
        chk("b2b_allowin", {63'd0, mem_allowin}, 64'd1);
        step();
        ex_to_mem_valid = 0; ex_rf_we = 0;
        settle();
        chk("b2b_second_wdata", {32'h0, mem_wb_rf_wdata}, 64'h22);
        chk("b2b_second_waddr", {59'd0, mem_wb_rf_waddr}, 64'd2);
        step();

        // ld.b at ...3 with two stall cycles
        issue(1, 1, 2'd0, 0, 32'h0000_2003, 5'd8);
        for (int s = 0; s < 2; s++) begin
            settle();
            chk("ldb_stall_to_wb", {63'd0, mem_to_wb_valid}, 64'd0);
            chk("ldb_stall_allowin", {63'd0, mem_allowin}, 64'd0);
            chk("ldb_stall_fwd", {63'd0, mem_fwd_stall}, 64'd1);
            step();
        end
        data_ok = 1; rdata = 32'h80FF_0000;
        settle();
        chk("ldb_to_wb", {63'd0, mem_to_wb_valid}, 64'd1);
        chk("ldb_wdata", {32'h0, mem_wb_rf_wdata}, 64'hFFFF_FF80);
        chk("ldb_allowin", {63'd0, mem_allowin}, 64'd1);
        chk("ldb_resp_fwd_stall", {63'd0, mem_fwd_stall}, FWD_EN ? 64'd0 : 64'd1);
        step();
        data_ok = 0;

        // ld.hu at ...2, response while WB is closed, WB opens three cycles later
        issue(1, 1, 2'd1, 1, 32'h0000_1002, 5'd6);
        data_ok = 1; rdata = 32'hBEEF_0000; wb_allowin = 0;
        settle();
        chk("ldhu_resp_to_wb", {63'd0, mem_to_wb_valid}, 64'd1);
        chk("ldhu_resp_wdata", {32'h0, mem_wb_rf_wdata}, 64'h0000_BEEF);
        chk("ldhu_resp_allowin", {63'd0, mem_allowin}, 64'd0);
        step();
        data_ok = 0; rdata = 32'h1111_2222;
        for (int h = 0; h < 2; h++) begin
            settle();
            chk("ldhu_held_to_wb", {63'd0, mem_to_wb_valid}, 64'd1);
            chk("ldhu_held_wdata", {32'h0, mem_wb_rf_wdata}, 64'h0000_BEEF);
            chk("ldhu_held_allowin", {63'd0, mem_allowin}, 64'd0);
            step();
        end
        wb_allowin = 1;
        settle();
        chk("ldhu_open_wdata", {32'h0, mem_wb_rf_wdata}, 64'h0000_BEEF);
        chk("ldhu_open_allowin", {63'd0, mem_allowin}, 64'd1);
        step();
        settle();
        chk("ldhu_gone", {63'd0, mem_to_wb_valid}, 64'd0);

        // extraction table, response in the first MEM cycle
        for (int i = 0; i < 15; i++) begin
            issue(1, 1, tbl[i].sz, tbl[i].uns, tbl[i].addr, 5'd10);
            data_ok = 1; rdata = tbl[i].rd[31:0]; rdata64 = tbl[i].rd;
            settle();
            if (tbl[i].is64) chk($sformatf("tbl%0d_wdata64", i), wb_wdata_64, tbl[i].exp);
            else chk($sformatf("tbl%0d_wdata32", i), {32'h0, mem_wb_rf_wdata}, tbl[i].exp);
            chk($sformatf("tbl%0d_to_wb", i), {63'd0, mem_to_wb_valid}, 64'd1);
            step();
            data_ok = 0;
        end

        // flush with a waiting load and a store request in EX: two responses discarded
        issue(1, 1, 2'd2, 0, 32'h500, 5'd7);
        flush = 1; ex_to_mem_valid = 1; ex_mem_req = 1; ex_is_load = 0; ex_rf_we = 0;
        settle();
        chk("flush_to_wb", {63'd0, mem_to_wb_valid}, 64'd0);
        step();
        flush = 0; ex_to_mem_valid = 0; ex_mem_req = 0;
        settle();
        chk("post_flush_to_wb", {63'd0, mem_to_wb_valid}, 64'd0);
        chk("post_flush_allowin", {63'd0, mem_allowin}, 64'd1);
        issue(1, 1, 2'd2, 0, 32'h600, 5'd9);
        data_ok = 1; rdata = 32'hDEAD_0001;
        settle();
        chk("drop1_to_wb", {63'd0, mem_to_wb_valid}, 64'd0);
        chk("drop1_allowin", {63'd0, mem_allowin}, 64'd0);
        step();
        rdata = 32'hDEAD_0002;
        settle();
        chk("drop2_to_wb", {63'd0, mem_to_wb_valid}, 64'd0);
        step();
        rdata = 32'h1234_5678;
        settle();
        chk("third_to_wb", {63'd0, mem_to_wb_valid}, 64'd1);
        chk("third_wdata", {32'h0, mem_wb_rf_wdata}, 64'h1234_5678);
        chk("third_waddr", {59'd0, mem_wb_rf_waddr}, 64'd9);
        step();
        data_ok = 0;
        settle();
        chk("third_gone", {63'd0, mem_to_wb_valid}, 64'd0);

        // reset mid-stall with one pending discard
        issue(1, 1, 2'd2, 0, 32'h700, 5'd2);
        flush = 1;
        step();
        flush = 0;
        issue(1, 1, 2'd2, 0, 32'h800, 5'd3);
        reset = 1;
        step();
        reset = 0;
        settle();
        chk("midrst_allowin", {63'd0, mem_allowin}, 64'd1);
        chk("midrst_to_wb", {63'd0, mem_to_wb_valid}, 64'd0);
        chk("midrst_fwd_stall", {63'd0, mem_fwd_stall}, 64'd0);
        chk("midrst_fwd_we", {63'd0, mem_fwd_we}, 64'd0);
        chk("midrst_pc", {32'h0, mem_wb_pc}, 64'd0);
        chk("midrst_waddr", {59'd0, mem_wb_rf_waddr}, 64'd0);
        chk("midrst_wdata", {32'h0, mem_wb_rf_wdata}, 64'd0);
        issue(1, 1, 2'd2, 0, 32'h900, 5'd4);
        data_ok = 1; rdata = 32'h0BAD_F00D;
        settle();
        chk("midrst_next_to_wb", {63'd0, mem_to_wb_valid}, 64'd1);
        chk("midrst_next_wdata", {32'h0, mem_wb_rf_wdata}, 64'h0BAD_F00D);
        step();
        data_ok = 0;

        // randomized traffic against the reference model
        for (int n = 0; n < 150; n++) begin
            kind  = $urandom_range(0, 3);
            a     = $urandom;
            sz    = 2'($urandom_range(0, 3));
            uns   = 1'($urandom_range(0, 1));
            wa    = 5'($urandom_range(1, 31));
            r32   = $urandom;
            r64   = {$urandom, $urandom};
            stall = $urandom_range(0, 3);
            hold  = $urandom_range(0, 2);
            if (kind == 0) begin
                issue(0, 0, 2'd0, 0, a, wa);
                settle();
                chk("rnd_alu_to_wb", {63'd0, mem_to_wb_valid}, 64'd1);
                chk("rnd_alu_wdata32", {32'h0, mem_wb_rf_wdata}, {32'h0, a});
                chk("rnd_alu_wdata64", wb_wdata_64, {32'h0, a});
                step();
            end else begin
                run_load(sz, uns, a, wa, r32, r64, stall, hold);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
